// File: rtl/universal_shift_reg.sv
// ============================================================================
// universal_shift_reg
// ----------------------------------------------------------------------------
// WIDTH-bit universal register used as a serialiser/deserialiser and datapath
// staging element. Supports hold, parallel load, clear, logical shifts with
// serial fill, an arithmetic right shift and rotates. It can also run a
// multi-cycle shift burst that reports progress on busy_o and done_o.
//
// Parameters
//   WIDTH     register width in bits (>= 2)
//   CNT_W     width of the burst shift-count input
//   RESET_VAL value q_o takes while rst_n is low
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        single-op enable (honoured only when idle)
//   mode_i    0 HOLD, 1 LOAD, 2 CLEAR, 3 SHL, 4 SHR, 5 ASR, 6 ROL, 7 ROR
//   d_i       parallel load data
//   ser_i     serial input bit (SHL fills the LSB, SHR fills the MSB)
//   start_i   start a burst (honoured only when idle; wins over en)
//   cnt_i     burst shift count, sampled together with start_i
//   q_o       register contents
//   ser_o     last bit shifted or rotated out (registered)
//   busy_o    high while a burst is still running
//   done_o    one-cycle pulse when a start_i request has completed
//   parity_o  (only with USHREG_PARITY_EN) registered XOR of q_o
//
// Build option
//   USHREG_PARITY_EN  adds the parity_o port and its register.
// ============================================================================
module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ser_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [WIDTH-1:0] q_o,
    output logic             ser_o,
    output logic             busy_o,
    output logic             done_o
`ifdef USHREG_PARITY_EN
    ,
    output logic             parity_o
`endif
);

    typedef enum logic [2:0] {
        M_HOLD  = 3'd0,
        M_LOAD  = 3'd1,
        M_CLEAR = 3'd2,
        M_SHL   = 3'd3,
        M_SHR   = 3'd4,
        M_ASR   = 3'd5,
        M_ROL   = 3'd6,
        M_ROR   = 3'd7
    } mode_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_r, state_nxt;
    mode_e            mode_r,  mode_nxt;   // mode latched at burst start
    logic [CNT_W-1:0] rem_r,   rem_nxt;    // shifts still to do in BURST
    logic [WIDTH-1:0] q_r,     q_nxt;
    logic             ser_r,   ser_nxt;
    logic             done_r,  done_nxt;

    // ------------------------------------------------------------------
    // Operation datapath: result of applying op_mode to the current value.
    // A running burst uses its latched mode; otherwise the live mode input.
    // ------------------------------------------------------------------
    mode_e            op_mode;
    logic [WIDTH-1:0] op_q;
    logic             op_ser;
    logic             op_is_shift;

    assign op_mode     = (state_r == S_BURST) ? mode_r : mode_e'(mode_i);
    assign op_is_shift = (op_mode >= M_SHL);

    always_comb begin
        op_q   = q_r;
        op_ser = ser_r;        // HOLD/LOAD/CLEAR leave ser_o alone
        case (op_mode)
            M_HOLD:  op_q = q_r;
            M_LOAD:  op_q = d_i;
            M_CLEAR: op_q = '0;
            M_SHL: begin
                op_q   = {q_r[WIDTH-2:0], ser_i};
                op_ser = q_r[WIDTH-1];
            end
            M_SHR: begin
                op_q   = {ser_i, q_r[WIDTH-1:1]};
                op_ser = q_r[0];
            end
            M_ASR: begin
                op_q   = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                op_ser = q_r[0];
            end
            M_ROL: begin
                op_q   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                op_ser = q_r[WIDTH-1];
            end
            M_ROR: begin
                op_q   = {q_r[0], q_r[WIDTH-1:1]};
                op_ser = q_r[0];
            end
            default: begin
                op_q   = q_r;
                op_ser = ser_r;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_r;
        mode_nxt  = mode_r;
        rem_nxt   = rem_r;
        q_nxt     = q_r;
        ser_nxt   = ser_r;
        done_nxt  = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    mode_nxt = mode_e'(mode_i);
                    if (!op_is_shift) begin
                        // Non-shift request behaves like a single op that
                        // still reports completion.
                        q_nxt    = op_q;
                        ser_nxt  = op_ser;
                        done_nxt = 1'b1;
                    end else if (cnt_i == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        // First shift happens on the start edge itself, so a
                        // burst of N shifts occupies exactly N edges.
                        q_nxt   = op_q;
                        ser_nxt = op_ser;
                        if (cnt_i == CNT_W'(1)) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt = S_BURST;
                            rem_nxt   = cnt_i - CNT_W'(1);
                        end
                    end
                end else if (en) begin
                    q_nxt   = op_q;
                    ser_nxt = op_ser;
                end
            end
            S_BURST: begin
                q_nxt   = op_q;
                ser_nxt = op_ser;
                if (rem_r == CNT_W'(1)) begin
                    state_nxt = S_IDLE;
                    rem_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    rem_nxt = rem_r - CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            mode_r  <= M_HOLD;
            rem_r   <= '0;
            q_r     <= RESET_VAL;
            ser_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            mode_r  <= mode_nxt;
            rem_r   <= rem_nxt;
            q_r     <= q_nxt;
            ser_r   <= ser_nxt;
            done_r  <= done_nxt;
        end
    end

    assign q_o    = q_r;
    assign ser_o  = ser_r;
    assign busy_o = (state_r == S_BURST);
    assign done_o = done_r;

`ifdef USHREG_PARITY_EN
    // Parity is computed from the value q takes at the same edge so it is
    // always coherent with q_o, without a combinational XOR tree on the output.
    logic parity_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_r <= ^RESET_VAL;
        else        parity_r <= ^q_nxt;
    end

    assign parity_o = parity_r;
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

    localparam int             W  = 8;
    localparam int             CW = 4;
    localparam logic [W-1:0]   RV = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n, en, ser_i, start_i;
    logic [2:0]    mode_i;
    logic [W-1:0]  d_i;
    logic [CW-1:0] cnt_i;
    logic [W-1:0]  q_o;
    logic          ser_o, busy_o, done_o;
`ifdef USHREG_PARITY_EN
    logic          parity_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: plain integers, arithmetic on byte values.
    int m_q, m_ser, m_rem, m_done, m_mode;

    universal_shift_reg #(.WIDTH(W), .CNT_W(CW), .RESET_VAL(RV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_i(mode_i), .d_i(d_i),
        .ser_i(ser_i), .start_i(start_i), .cnt_i(cnt_i),
        .q_o(q_o), .ser_o(ser_o), .busy_o(busy_o), .done_o(done_o)
`ifdef USHREG_PARITY_EN
        , .parity_o(parity_o)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    task automatic model_reset();
        m_q = int'(RV); m_ser = 0; m_rem = 0; m_done = 0; m_mode = 0;
    endtask

    task automatic model_op(input int md);
        int s;
        int outb;
        s    = int'(ser_i);
        outb = m_ser;
        case (md)
            1: m_q = int'(d_i);
            2: m_q = 0;
            3: begin outb = m_q / 128; m_q = (m_q * 2 + s) % 256; end
            4: begin outb = m_q % 2;   m_q = m_q / 2 + s * 128; end
            5: begin outb = m_q % 2;   m_q = m_q / 2 + (m_q / 128) * 128; end
            6: begin outb = m_q / 128; m_q = (m_q * 2) % 256 + m_q / 128; end
            7: begin outb = m_q % 2;   m_q = m_q / 2 + (m_q % 2) * 128; end
            default: ;
        endcase
        m_ser = outb;
    endtask

    task automatic model_edge();
        m_done = 0;
        if (!rst_n) begin
            model_reset();
        end else if (m_rem > 0) begin
            model_op(m_mode);
            m_rem  = m_rem - 1;
            m_done = (m_rem == 0) ? 1 : 0;
        end else if (start_i) begin
            m_mode = int'(mode_i);
            if (m_mode < 3) begin
                model_op(m_mode);
                m_done = 1;
            end else if (cnt_i == 0) begin
                m_done = 1;
            end else begin
                model_op(m_mode);
                m_rem  = int'(cnt_i) - 1;
                m_done = (m_rem == 0) ? 1 : 0;
            end
        end else if (en) begin
            model_op(int'(mode_i));
        end
    endtask

    function automatic logic [11:0] exp_vec();
        logic [7:0] b;
        logic       par;
        b = m_q[7:0];
`ifdef USHREG_PARITY_EN
        par = ^b;
`else
        par = 1'b0;
`endif
        return {b, m_ser[0], (m_rem > 0), m_done[0], par};
    endfunction

    function automatic logic [11:0] obs_vec();
        logic par;
`ifdef USHREG_PARITY_EN
        par = parity_o;
`else
        par = 1'b0;
`endif
        return {q_o, ser_o, busy_o, done_o, par};
    endfunction

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; start_i = 1'b0; mode_i = 3'd0; d_i = '0; ser_i = 1'b0; cnt_i = '0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({q_o, ser_o, busy_o, done_o} !== {RV, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_async: got q=%h ser=%b busy=%b done=%b want q=%h 0 0 0",
                     q_o, ser_o, busy_o, done_o, RV);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_hold: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single_ops();
        en = 1'b1; mode_i = 3'd1; d_i = 8'h81;
        step();
        mode_i = 3'd3; ser_i = 1'b0;
        step();
        vectors++;
        if (q_o !== 8'h02 || ser_o !== 1'b1) begin
            miscompares++;
            $display("FAIL shl_81: got q=%h ser=%b want q=02 ser=1", q_o, ser_o);
        end
        mode_i = 3'd1;
        step();
        mode_i = 3'd5;
        step();
        vectors++;
        if (q_o !== 8'hC0 || ser_o !== 1'b1) begin
            miscompares++;
            $display("FAIL asr_81: got q=%h ser=%b want q=c0 ser=1", q_o, ser_o);
        end
        for (int i = 0; i < 60; i++) begin
            en     = 1'($urandom);
            mode_i = 3'($urandom);
            d_i    = 8'($urandom);
            ser_i  = 1'($urandom);
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL single_op[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        idle_inputs();
    endtask

    task automatic test_burst_rol();
        int nbusy = 0;
        int ndone = 0;
        en = 1'b1; mode_i = 3'd1; d_i = 8'h96;
        step();
        en = 1'b0; start_i = 1'b1; mode_i = 3'd6; cnt_i = 4'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            start_i = 1'b0; mode_i = 3'($urandom); cnt_i = 4'($urandom);
            if (busy_o === 1'b1) nbusy++;
            if (done_o === 1'b1) ndone++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL burst_rol[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (q_o !== 8'hB4 || nbusy != 2 || ndone != 1) begin
            miscompares++;
            $display("FAIL burst_rol_sum: got q=%h busy=%0d done=%0d want q=b4 busy=2 done=1",
                     q_o, nbusy, ndone);
        end
        idle_inputs();
    endtask

    task automatic test_cnt_zero();
        logic [W-1:0] q0;
        int nbusy = 0;
        int ndone = 0;
        logic first_done;
        q0 = q_o;
        start_i = 1'b1; mode_i = 3'd4; cnt_i = 4'd0; ser_i = 1'b1;
        step();
        first_done = done_o;
        idle_inputs();
        if (busy_o === 1'b1) nbusy++;
        if (done_o === 1'b1) ndone++;
        step();
        if (busy_o === 1'b1) nbusy++;
        if (done_o === 1'b1) ndone++;
        vectors++;
        if (q_o !== q0 || first_done !== 1'b1 || nbusy != 0 || ndone != 1) begin
            miscompares++;
            $display("FAIL cnt_zero: got q=%h done1=%b busy=%0d done=%0d want q=%h done1=1 busy=0 done=1",
                     q_o, first_done, nbusy, ndone, q0);
        end
    endtask

    task automatic test_burst_ignore();
        logic [7:0] st;
        int ndone = 0;
        st = 8'b0100_1101;   // st[i] is the i-th serial bit fed in
        en = 1'b1; mode_i = 3'd1; d_i = 8'($urandom);
        step();
        en = 1'b0; start_i = 1'b1; mode_i = 3'd4; cnt_i = 4'd8; ser_i = st[0];
        for (int i = 0; i < 9; i++) begin
            step();
            if (done_o === 1'b1) ndone++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL burst_ignore[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 7) begin
                vectors++;
                if (q_o !== 8'h4D || busy_o !== 1'b0 || done_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL burst_shr8: got q=%h busy=%b done=%b want q=4d busy=0 done=1",
                             q_o, busy_o, done_o);
                end
            end
            // Garbage on the control inputs must not disturb the burst.
            en      = 1'($urandom);
            mode_i  = 3'($urandom);
            start_i = (i < 7) ? 1'($urandom) : 1'b0;
            cnt_i   = 4'($urandom);
            d_i     = 8'($urandom);
            if (i < 7) ser_i = st[i+1];
            if (i == 7) en = 1'b0;
        end
        vectors++;
        if (ndone != 1) begin
            miscompares++;
            $display("FAIL burst_done_cnt: got %0d pulses want 1", ndone);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int guard;
        for (int b = 0; b < 25; b++) begin
            start_i = 1'b1;
            mode_i  = (b % 4 == 3) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            cnt_i   = 4'($urandom);
            d_i     = 8'($urandom);
            ser_i   = 1'($urandom);
            en      = 1'($urandom);
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b_start[%0d]: got %h want %h", b, obs_vec(), exp_vec());
            end
            guard = 0;
            while (m_rem > 0 && guard < 20) begin
                start_i = 1'($urandom); en = 1'($urandom); mode_i = 3'($urandom);
                ser_i = 1'($urandom); cnt_i = 4'($urandom);
                step();
                guard++;
                vectors++;
                if (obs_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL b2b_burst[%0d.%0d]: got %h want %h", b, guard, obs_vec(), exp_vec());
                end
            end
            if (guard >= 20) begin
                miscompares++;
                $display("FAIL b2b_timeout[%0d]: burst did not finish", b);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_burst();
        int ndone = 0;
        start_i = 1'b1; mode_i = 3'd6; cnt_i = 4'd10;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) step();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({q_o, ser_o, busy_o, done_o} !== {RV, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_mid_burst: got q=%h ser=%b busy=%b done=%b want q=%h 0 0 0",
                     q_o, ser_o, busy_o, done_o, RV);
        end
        step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done_o === 1'b1) ndone++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL post_abort[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (ndone != 0) begin
            miscompares++;
            $display("FAIL abort_done: got %0d pulses want 0", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_burst_rol();
        test_cnt_zero();
        test_burst_ignore();
        test_back_to_back();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
